// File: rtl/sdrc_wb_pkg.sv
// Shared types and constants for the sdrc Wishbone arbiter.
package sdrc_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StErr,
    StDrain
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_wb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_M = 2
) (
  input  logic [NUM_M-1:0]         req,
  input  logic [$clog2(NUM_M)-1:0] ptr,
  output logic [$clog2(NUM_M)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IW = $clog2(NUM_M);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
    for (int i = NUM_M - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % NUM_M);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter with a per-transfer ack watchdog in front of sdrc_top.
module sdrc_wb_arbiter
  import sdrc_wb_pkg::*;
#(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               wb_clk_i,
  input  logic               resetn,
  input  logic [NUM_M-1:0]   m_cyc_i,
  input  logic [NUM_M-1:0]   m_stb_i,
  input  logic [NUM_M-1:0]   m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  input  logic [NUM_M*4-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0] m_cti_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NUM_M-1:0]   m_ack_o,
  output logic [NUM_M-1:0]   m_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_addr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [3:0]         s_sel_o,
  output logic [2:0]         s_cti_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  output logic [NUM_M-1:0]   grant_o,
  output logic               timeout_o
);

  localparam int unsigned IW = $clog2(NUM_M);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW-1:0] owner_next;
  logic          own;
  logic          owner_cyc;
  logic          fire;

  rr_pick #(
    .NUM_M(NUM_M)
  ) u_rr_pick (
    .req  (m_cyc_i),
    .ptr  (rr_q),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign own        = (state_q == StOwn);
  assign owner_cyc  = m_cyc_i[owner_q];
  assign owner_next = (owner_q == IW'(NUM_M - 1)) ? '0 : owner_q + 1'b1;
  assign fire       = (TIMEOUT != 0) && own && s_stb_o && !s_ack_i && (cnt_q == CNT_LAST);
  assign m_dat_o    = s_dat_i;
  assign timeout_o  = (state_q == StErr);

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    grant_o  = '0;
    if (own) begin
      s_cyc_o           = m_cyc_i[owner_q];
      s_stb_o           = m_stb_i[owner_q];
      s_we_o            = m_we_i[owner_q];
      s_addr_o          = m_addr_i[owner_q*AW +: AW];
      s_dat_o           = m_dat_i[owner_q*DW +: DW];
      s_sel_o           = m_sel_i[owner_q*4 +: 4];
      s_cti_o           = m_cti_i[owner_q*3 +: 3];
      m_ack_o[owner_q]  = s_ack_i;
    end
    if (state_q == StErr) begin
      m_err_o[owner_q] = 1'b1;
    end
    if (state_q != StIdle) begin
      grant_o[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwn;
          owner_d = pick_idx;
        end
      end
      StOwn: begin
        // A dropped cyc beats a watchdog expiry in the same cycle.
        if (!owner_cyc) begin
          state_d = StIdle;
          rr_d    = owner_next;
        end else if (fire) begin
          state_d = StErr;
        end
      end
      StErr: state_d = StDrain;
      StDrain: begin
        if (!owner_cyc) begin
          state_d = StIdle;
          rr_d    = owner_next;
        end
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (own && (state_d == StOwn) && s_stb_o && !s_ack_i) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed, table-driven bench for sdrc_wb_arbiter with two masters and TIMEOUT = 8.
module tb_sdrc_wb_arbiter;
  import sdrc_wb_pkg::*;

  localparam int unsigned NUM_M   = 2;
  localparam int unsigned AW      = 26;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [31:0] BEEF    = 32'hDEADBEEF;

  logic                 clk    = 1'b0;
  logic                 resetn = 1'b0;
  logic [NUM_M-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]  m_addr_i;
  logic [NUM_M*DW-1:0]  m_dat_i;
  logic [NUM_M*4-1:0]   m_sel_i;
  logic [NUM_M*3-1:0]   m_cti_i;
  logic [DW-1:0]        m_dat_o;
  logic [NUM_M-1:0]     m_ack_o, m_err_o;
  logic                 s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]        s_addr_o;
  logic [DW-1:0]        s_dat_o;
  logic [3:0]           s_sel_o;
  logic [2:0]           s_cti_o;
  logic [DW-1:0]        s_dat_i;
  logic                 s_ack_i;
  logic [NUM_M-1:0]     grant_o;
  logic                 timeout_o;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic [31:0] dat;
    logic [1:0]  grant;
    logic        scyc;
    logic        sstb;
    logic [1:0]  mack;
    logic [1:0]  merr;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  sdrc_wb_arbiter #(
    .NUM_M  (NUM_M),
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i (clk),
    .resetn   (resetn),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_addr_i (m_addr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_cti_i  (m_cti_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_cti_o  (s_cti_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic r(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                   input logic ack, input logic [31:0] dat, input logic [1:0] grant,
                   input logic scyc, input logic sstb, input logic [1:0] mack,
                   input logic [1:0] merr, input logic to);
    vec_t t;
    t.rst = rst; t.cyc = cyc; t.stb = stb; t.ack = ack; t.dat = dat;
    t.grant = grant; t.scyc = scyc; t.sstb = sstb; t.mack = mack; t.merr = merr; t.to = to;
    tbl.push_back(t);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
    @(posedge clk);
    #1;
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = ack;
    s_dat_i = '0;
    @(negedge clk);
  endtask

  initial begin
    m_cyc_i  = '0;
    m_stb_i  = '0;
    m_we_i   = 2'b10;
    m_addr_i = {26'h0000200, 26'h0000100};
    m_dat_i  = {32'h12345678, 32'hA5A5A5A5};
    m_sel_i  = {4'hA, 4'h5};
    m_cti_i  = {CTI_INCR, CTI_CLASSIC};
    s_ack_i  = 1'b0;
    s_dat_i  = '0;

    // Single master classic read, ack on the third granted cycle.
    r(0, 2'b01, 2'b01, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 1, BEEF, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Contention from reset: master 0 first, master 1 two cycles after the drop, then 0 again.
    r(1, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 1, '0,   2'b01, 1, 1, 2'b01, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b10, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 1, '0,   2'b10, 1, 1, 2'b10, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b10, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Master 1 four-beat burst with a stb gap; master 0 waits.
    r(0, 2'b10, 2'b10, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b10, 0, '0,   2'b10, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b10, 1, '0,   2'b10, 1, 1, 2'b10, 2'b00, 0);
    r(0, 2'b11, 2'b00, 0, '0,   2'b10, 1, 0, 2'b00, 2'b00, 0);
    repeat (3) r(0, 2'b11, 2'b10, 1, '0, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b10, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Watchdog: no ack for 8 cycles of stb, one-cycle error, drain, then master 1.
    r(0, 2'b01, 2'b01, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    repeat (8) r(0, 2'b11, 2'b01, 0, '0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b01, 0, '0,   2'b01, 0, 0, 2'b00, 2'b01, 1);
    repeat (2) r(0, 2'b11, 2'b01, 0, '0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Ack on the eighth wait cycle is a normal ack.
    repeat (7) r(0, 2'b10, 2'b10, 0, '0, 2'b10, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 1, '0,   2'b10, 1, 1, 2'b10, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b10, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b00, 0, '0,   2'b10, 1, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b10, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Move the pointer to 1, reset during master 1's second beat, then master 0 wins.
    r(0, 2'b01, 2'b01, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b01, 2'b01, 1, '0,   2'b01, 1, 1, 2'b01, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 0, '0,   2'b10, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b10, 2'b10, 1, '0,   2'b10, 1, 1, 2'b10, 2'b00, 0);
    r(1, 2'b10, 2'b10, 1, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b11, 2'b11, 0, '0,   2'b01, 1, 1, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b01, 0, 0, 2'b00, 2'b00, 0);
    r(0, 2'b00, 2'b00, 0, '0,   2'b00, 0, 0, 2'b00, 2'b00, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {grant_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o,
                            s_cti_o, m_ack_o, m_err_o, timeout_o}, '0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      resetn  = !tbl[i].rst;
      m_cyc_i = tbl[i].cyc;
      m_stb_i = tbl[i].stb;
      s_ack_i = tbl[i].ack;
      s_dat_i = tbl[i].dat;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o, m_dat_o},
            {tbl[i].grant, tbl[i].scyc, tbl[i].sstb, tbl[i].mack, tbl[i].merr, tbl[i].to,
             tbl[i].dat});
    end

    // Slave-side data path follows the owner and is quiet when idle (pointer is at 1 here).
    step(2'b10, 2'b10, 1'b0);
    check("idle_sbus", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o}, '0);
    step(2'b10, 2'b10, 1'b0);
    check("own_sbus", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o},
          {1'b1, 1'b1, 1'b1, 26'h0000200, 32'h12345678, 4'hA, CTI_INCR});
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    // cyc drops in the very cycle the watchdog would fire: no error, bus goes idle.
    step(2'b01, 2'b01, 1'b0);
    repeat (7) step(2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    check("drop_at_limit_err", {m_err_o, timeout_o}, '0);
    step(2'b00, 2'b00, 1'b0);
    check("drop_beats_timeout", {grant_o, m_err_o, timeout_o}, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
